rv_instr_encoder: RTL and testbench
===================================

RV_INSTR_ENCODER -- requirements
Module: rv_instr_encoder

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the instruction memory capacity in words (power of two, 4..1024).
REQ-002 Parameter AW, default 8, SHALL set the word-address width, with log2(DEPTH) = AW.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start  in  1  one-cycle pulse: begin a program at word address 0.
REQ-006 in_valid  in  1  instruction request valid.
REQ-007 in_ready  out  1  encoder can accept a request.
REQ-008 in_class  in  3  0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE(ALU-imm), 5 JAL, 6-7 illegal.
REQ-009 in_funct3  in  3  funct3 field.
REQ-010 in_funct7b  in  1  instruction bit 30 (sub/sra select), used by RTYPE only.
REQ-011 in_rd, in_rs1, in_rs2  in  5 each  register indices.
REQ-012 in_imm  in  21  signed immediate; the low 12/12/13/21 bits are used for I/S/B/J.
REQ-013 in_last  in  1  marks the final instruction of the program.
REQ-014 wr_en  out  1  instruction-memory write strobe.
REQ-015 wr_addr  out  AW  word address of the write.
REQ-016 wr_data  out  32  encoded instruction.
REQ-017 busy  out  1  high in RUN; done  out  1  high in DONE; err  out  1  sticky error flag.
REQ-018 count  out  AW+1  number of words written since start.

Function
REQ-019 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL equal (state==RUN).
REQ-020 IDLE or DONE with start=1 -> RUN: clear count, write pointer and err.
REQ-021 start in RUN SHALL be ignored.
REQ-022 A request SHALL be accepted when in_valid and in_ready are both high.
REQ-023 For an accepted request, wr_en, wr_addr and wr_data SHALL be registered and valid exactly one cycle after acceptance; otherwise wr_en=0.
REQ-024 Encodings SHALL be:
- LOAD op 0000011 = {imm[11:0],rs1,f3,rd,op}
- ITYPE op 0010011 = {imm[11:0],rs1,f3,rd,op}
- STORE op 0100011 = {imm[11:5],rs2,rs1,f3,imm[4:0],op}
- RTYPE op 0110011 = {0,f7b,00000,rs2,rs1,f3,rd,op}
- BRANCH op 1100011 = {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}
- JAL op 1101111 = {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
REQ-025 An illegal class, or BRANCH/JAL with imm[0]=1, SHALL write NOP 0x00000013 and set err; err SHALL hold until the next start or reset.
REQ-026 wr_addr SHALL start at 0 and increment by 1 per write; count SHALL increment by 1 on each write.
REQ-027 An accept with in_last=1 SHALL move the FSM to DONE in the next cycle.
REQ-028 An accept that fills word DEPTH-1 SHALL move the FSM to DONE whatever in_last is.
REQ-029 Full has priority: a fill without in_last SHALL also set err.
REQ-030 In DONE, in_valid SHALL be ignored and no writes issued; count SHALL hold the final value (max DEPTH, no wrap).
REQ-031 A start and an accept in the same cycle cannot occur, because in_ready=0 outside RUN.

Reset
REQ-032 With rst_n=0 at a clock edge: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, count=0.
REQ-033 Reset asserted mid-program SHALL suppress any pending write on the following edge; memory contents already written are not the block's concern.

Verification
REQ-034 start, then accept ITYPE f3=0 rd=1 rs1=0 imm=5 -> next cycle wr_en=1, wr_addr=0, wr_data=0x00500093.
REQ-035 RTYPE f3=0 rd=3 rs1=1 rs2=2, with f7b=0 then f7b=1 -> 0x002081B3 at addr 0, 0x402081B3 at addr 1, count=2.
REQ-036 BRANCH f3=0 rs1=1 rs2=2 imm=8 -> 0x00208463; JAL rd=1 imm=8 with in_last=1 -> 0x008000EF, then done=1, in_ready=0.
REQ-037 Class 7, and BRANCH with imm=3 -> each writes 0x00000013, err=1 and stays high; the next start clears err.
REQ-038 DEPTH=4, stream 4 requests with no in_last -> writes at addresses 0..3, then DONE, count=4, err=1, and a 5th in_valid is not accepted.
REQ-039 rst_n=0 for one cycle during a stream -> no wr_en on the following edge, and all outputs at their reset values.

Source files
------------

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: accepts decoded instruction requests and writes
// the encoded 32-bit words sequentially into an instruction memory port.
module rv_instr_encoder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_class,
    input  logic [2:0]    in_funct3,
    input  logic          in_funct7b,
    input  logic [4:0]    in_rd,
    input  logic [4:0]    in_rs1,
    input  logic [4:0]    in_rs2,
    input  logic [20:0]   in_imm,
    input  logic          in_last,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   count,
    output logic [1:0]    dbg_state
);

    // Handshake: a request transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on the FSM state.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          err_q, err_d;
    logic [AW:0]   count_q, count_d;

    logic          accept;
    logic          illegal;
    logic [31:0]   enc_word;

    assign accept = in_valid && (state_q == S_RUN);

    always_comb begin
        enc_word = NOP;
        illegal  = 1'b0;
        case (in_class)
            3'd0: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd2: enc_word = {1'b0, in_funct7b, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
                illegal  = in_imm[0];
            end
            3'd4: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                illegal  = in_imm[0];
            end
            default: illegal = 1'b1;
        endcase
        // Misaligned branch/jump targets and unknown classes become a NOP.
        if (illegal) begin
            enc_word = NOP;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        count_d   = count_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    count_d   = '0;
                    wr_addr_d = '0;
                    err_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = count_q[AW-1:0];
                    wr_data_d = enc_word;
                    count_d   = count_q + (AW+1)'(1);
                    if (illegal) begin
                        err_d = 1'b1;
                    end
                    // Filling the last word ends the program; missing in_last there is an error.
                    if (count_q == LAST_IDX) begin
                        state_d = S_DONE;
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end else if (in_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
            count_q   <= count_d;
        end
    end

    assign in_ready  = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed vectors with literal expectations, plus a
// program-level reference model compared against the 256-word instance every cycle.
module tb_rv_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [20:0] in_imm;
  logic        in_last;

  logic        in_ready, wr_en, busy, done, err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  count;
  logic [1:0]  dbg_state;

  logic        in_ready4, wr_en4, busy4, done4, err4;
  logic [1:0]  wr_addr4;
  logic [31:0] wr_data4;
  logic [2:0]  count4;
  logic [1:0]  dbg_state4;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  logic [39:0] exp_q[$];
  int m_phase   = 0;
  int m_written = 0;
  bit m_err     = 1'b0;

  rv_instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b(in_funct7b),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .count(count), .dbg_state(dbg_state)
  );

  rv_instr_encoder #(.DEPTH(4), .AW(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .in_class(in_class), .in_funct3(in_funct3), .in_funct7b(in_funct7b),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .err(err4), .count(count4), .dbg_state(dbg_state4)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit ref_bad(input logic [2:0] c, input logic [20:0] imm);
    return (c > 3'd5) || (((c == 3'd3) || (c == 3'd5)) && imm[0]);
  endfunction

  // Reference encoder: builds each field by shifting it into its bit position.
  function automatic logic [31:0] ref_word(input logic [2:0] c, input logic [2:0] f3,
                                           input logic f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [20:0] imm);
    logic [31:0] base;
    logic [31:0] r;
    base = (32'(rs1) << 15) | (32'(f3) << 12);
    if (ref_bad(c, imm)) return 32'h13;
    case (c)
      3'd0: r = (32'(imm[11:0]) << 20) | base | (32'(rd) << 7) | 32'h03;
      3'd1: r = (32'(imm[11:5]) << 25) | (32'(rs2) << 20) | base | (32'(imm[4:0]) << 7) | 32'h23;
      3'd2: r = (32'(f7) << 30) | (32'(rs2) << 20) | base | (32'(rd) << 7) | 32'h33;
      3'd3: r = (32'(imm[12]) << 31) | (32'(imm[10:5]) << 25) | (32'(rs2) << 20) | base
              | (32'(imm[4:1]) << 8) | (32'(imm[11]) << 7) | 32'h63;
      3'd4: r = (32'(imm[11:0]) << 20) | base | (32'(rd) << 7) | 32'h13;
      default: r = (32'(imm[20]) << 31) | (32'(imm[10:1]) << 21) | (32'(imm[11]) << 20)
                 | (32'(imm[19:12]) << 12) | (32'(rd) << 7) | 32'h6F;
    endcase
    return r;
  endfunction

  // Program-level model: phase 0 idle, 1 running, 2 finished.
  initial begin
    forever begin
      @(posedge clk);
      exp_q.delete();
      if (!rst_n) begin
        m_phase = 0; m_written = 0; m_err = 1'b0;
      end else if (m_phase != 1) begin
        if (start) begin
          m_phase = 1; m_written = 0; m_err = 1'b0;
        end
      end else if (in_valid) begin
        exp_q.push_back({8'(m_written),
                         ref_word(in_class, in_funct3, in_funct7b, in_rd, in_rs1, in_rs2, in_imm)});
        if (ref_bad(in_class, in_imm)) m_err = 1'b1;
        m_written++;
        if (m_written == 256) begin
          m_phase = 2;
          if (!in_last) m_err = 1'b1;
        end else if (in_last) begin
          m_phase = 2;
        end
      end
    end
  end

  // scoreboard compare
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("sb_wr_en", 32'(wr_en), 32'(exp_q.size() > 0));
        if (wr_en && exp_q.size() > 0) begin
          chk("sb_wr_addr", 32'(wr_addr), 32'(exp_q[0][39:32]));
          chk("sb_wr_data", wr_data, exp_q[0][31:0]);
        end
        chk("sb_in_ready", 32'(in_ready), 32'(m_phase == 1));
        chk("sb_busy", 32'(busy), 32'(m_phase == 1));
        chk("sb_done", 32'(done), 32'(m_phase == 2));
        chk("sb_err", 32'(err), 32'(m_err));
        chk("sb_count", 32'(count), 32'(m_written));
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic req(input logic [2:0] c, input logic [2:0] f3, input logic f7,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [20:0] imm, input logic last,
                     input bit lit, input logic [31:0] ea, input logic [31:0] ed, input string nm);
    in_valid = 1'b1; in_class = c; in_funct3 = f3; in_funct7b = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    @(posedge clk); #1;
    if (lit) begin
      chk({nm, "_wr_en"}, 32'(wr_en), 32'd1);
      chk({nm, "_wr_addr"}, 32'(wr_addr), ea);
      chk({nm, "_wr_data"}, wr_data, ed);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_class = '0; in_funct3 = '0;
    in_funct7b = 1'b0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;

    // pin the reference encoder against hand-assembled words
    chk("pin_itype", ref_word(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5), 32'h00500093);
    chk("pin_store", ref_word(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 21'd12), 32'h0020A623);
    chk("pin_branch_neg", ref_word(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFF8), 32'hFE208CE3);
    chk("pin_jal", ref_word(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8), 32'h008000EF);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(count), 0);
    rst_n = 1'b1;
    checking = 1'b1;

    // small-memory fill without in_last
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      req(3'd4, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 21'(i), 1'b0, 1'b0, 0, 0, "d4");
      chk("d4_wr_en", 32'(wr_en4), 1);
      chk("d4_wr_addr", 32'(wr_addr4), 32'(i));
    end
    chk("d4_done", 32'(done4), 1);
    chk("d4_count", 32'(count4), 4);
    chk("d4_err", 32'(err4), 1);
    chk("d4_in_ready", 32'(in_ready4), 0);
    @(posedge clk); #1;
    chk("d4_no_fifth_write", 32'(wr_en4), 0);
    chk("d4_count_hold", 32'(count4), 4);
    req(3'd4, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 21'd0, 1'b1, 1'b0, 0, 0, "end1");
    in_valid = 1'b0;

    // single ITYPE program
    pulse_start();
    req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b1, 1'b1, 0, 32'h00500093, "addi");

    // mixed program
    pulse_start();
    req(3'd2, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 0, 32'h002081B3, "add");
    req(3'd2, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 21'd0, 1'b0, 1'b1, 1, 32'h402081B3, "sub");
    chk("rtype_count", 32'(count), 2);
    req(3'd1, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 21'd12, 1'b0, 1'b1, 2, 32'h0020A623, "sw");
    req(3'd0, 3'd2, 1'b0, 5'd3, 5'd1, 5'd0, 21'h1FFFFC, 1'b0, 1'b1, 3, 32'hFFC0A183, "lw");
    req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'h1FFFF8, 1'b0, 1'b1, 4, 32'hFE208CE3, "beq_neg");
    pulse_start();
    chk("start_in_run_busy", 32'(busy), 1);
    chk("start_in_run_count", 32'(count), 5);
    req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd8, 1'b0, 1'b1, 5, 32'h00208463, "beq");
    req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd8, 1'b1, 1'b1, 6, 32'h008000EF, "jal");
    chk("jal_done", 32'(done), 1);
    chk("jal_in_ready", 32'(in_ready), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("done_no_write", 32'(wr_en), 0);
      chk("done_count_hold", 32'(count), 7);
    end
    in_valid = 1'b0;

    // illegal encodings and sticky error
    pulse_start();
    req(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 21'd0, 1'b0, 1'b1, 0, 32'h00000013, "class7");
    chk("class7_err", 32'(err), 1);
    req(3'd3, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 21'd3, 1'b0, 1'b1, 1, 32'h00000013, "beq_odd");
    req(3'd5, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd9, 1'b0, 1'b1, 2, 32'h00000013, "jal_odd");
    req(3'd4, 3'd0, 1'b0, 5'd5, 5'd6, 5'd0, 21'h7FF, 1'b1, 1'b1, 3, 32'h7FF30293, "addi_max");
    chk("err_sticky", 32'(err), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("err_sticky_done", 32'(err), 1);
    pulse_start();
    chk("start_clears_err", 32'(err), 0);
    chk("start_clears_count", 32'(count), 0);

    // fill the 256-word memory without in_last
    for (int i = 0; i < 256; i++) begin
      req((i % 3 == 0) ? 3'd2 : 3'd4, 3'(i), 1'(i >> 1), 5'(i), 5'(i + 7), 5'(i * 3),
          21'(i * 37), 1'b0, 1'b0, 0, 0, "fill");
    end
    chk("fill_done", 32'(done), 1);
    chk("fill_count", 32'(count), 256);
    chk("fill_err", 32'(err), 1);
    chk("fill_in_ready", 32'(in_ready), 0);

    // small-memory fill that coincides with in_last
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      req(3'd4, 3'd1, 1'b0, 5'd2, 5'd3, 5'd0, 21'(i), 1'(i == 3), 1'b0, 0, 0, "d4b");
    end
    in_valid = 1'b0;
    chk("d4_last_done", 32'(done4), 1);
    chk("d4_last_err", 32'(err4), 0);
    chk("d4_last_count", 32'(count4), 4);

    // reset during a stream
    pulse_start();
    req(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 21'd5, 1'b0, 1'b1, 0, 32'h00500093, "pre_rst");
    in_valid = 1'b1; in_rd = 5'd7; in_imm = 21'd99;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_d4_wr_en", 32'(wr_en4), 0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
